// File: rtl/pipelined_rca_adder_if.sv
// Operand/result handshake bundle for pipelined_rca_adder.
// With PIPELINED_RCA_ADDER_SAT_EN defined the bundle also carries 'sat'.
interface pipelined_rca_adder_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c0;
  logic             sub;
`ifdef PIPELINED_RCA_ADDER_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;

`ifdef PIPELINED_RCA_ADDER_SAT_EN
  modport master (output in_valid, a, b, c0, sub, sat, out_ready,
                  input  in_ready, out_valid, s, c, ovf);
  modport slave  (input  in_valid, a, b, c0, sub, sat, out_ready,
                  output in_ready, out_valid, s, c, ovf);
`else
  modport master (output in_valid, a, b, c0, sub, out_ready,
                  input  in_ready, out_valid, s, c, ovf);
  modport slave  (input  in_valid, a, b, c0, sub, out_ready,
                  output in_ready, out_valid, s, c, ovf);
`endif
endinterface

// File: rtl/pipelined_rca_adder.sv
// pipelined_rca_adder: WIDTH-bit add/subtract split into STAGES ripple-carry
// slices, one register boundary per slice, carry handed stage to stage.
// Upper operand slices ride along (input skew) and finished lower sum slices
// accumulate so the whole result leaves aligned after STAGES registers.
// Optional macro PIPELINED_RCA_ADDER_SAT_EN adds a 'sat' input that clamps
// an overflowing result in the last stage.

// One SW-bit ripple slice; also reports the carry into its top bit so the
// last slice can form the signed overflow flag.
module pipelined_rca_adder_slice #(parameter int SW = 8) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_ci,
  output logic [SW-1:0] o_s,
  output logic          o_co,
  output logic          o_cm
);
  logic w_cy;

  // Bit-serial ripple carry through the slice
  always_comb begin
    o_s  = '0;
    o_cm = 1'b0;
    w_cy = i_ci;
    for (int i = 0; i < SW; i++) begin
      if (i == SW-1) o_cm = w_cy;
      o_s[i] = i_a[i] ^ i_b[i] ^ w_cy;
      w_cy   = (i_a[i] & i_b[i]) | (w_cy & (i_a[i] ^ i_b[i]));
    end
    o_co = w_cy;
  end
endmodule

module pipelined_rca_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_rca_adder_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  logic              w_en;
  logic              w_acc;
  logic              r_ovf;
  logic [STAGES-1:0] r_vld;
  logic [STAGES:0]   w_vld_pipe;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c_eff;

  // Single global enable: the whole pipe moves or the whole pipe holds
  assign w_en         = ~r_vld[STAGES-1] | bus.out_ready;
  assign w_acc        = bus.in_valid & w_en;
  assign bus.in_ready = w_en;

  // Subtract is a + ~b + ~borrow
  assign w_b_eff = bus.sub ? ~bus.b : bus.b;
  assign w_c_eff = bus.c0 ^ bus.sub;

  // Valid shift register; a non-accepted enabled cycle shifts in a bubble
  assign w_vld_pipe = {r_vld, w_acc};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_vld <= '0;
    else if (w_en) r_vld <= w_vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int IW = WIDTH - k*SW;   // operand bits still to be added
    localparam int OW = (k+1)*SW;       // sum bits finished after this stage

    logic [IW-1:0] w_ain;
    logic [IW-1:0] w_bin;
    logic          w_cin;
    logic [SW-1:0] w_ssl;
    logic          w_co;
    logic          w_cm;
    logic [OW-1:0] w_snx;
    logic [OW-1:0] w_sum_d;
    logic [OW-1:0] r_sum;
    logic          r_cy;
`ifdef PIPELINED_RCA_ADDER_SAT_EN
    logic          w_sat_in;
`endif

    if (k == 0) begin : g_first
      assign w_ain = bus.a;
      assign w_bin = w_b_eff;
      assign w_cin = w_c_eff;
      assign w_snx = w_ssl;
`ifdef PIPELINED_RCA_ADDER_SAT_EN
      assign w_sat_in = bus.sat;
`endif
    end else begin : g_next
      assign w_ain = stg[k-1].g_skew.r_au;
      assign w_bin = stg[k-1].g_skew.r_bu;
      assign w_cin = stg[k-1].r_cy;
      assign w_snx = {w_ssl, stg[k-1].r_sum};
`ifdef PIPELINED_RCA_ADDER_SAT_EN
      assign w_sat_in = stg[k-1].g_skew.r_sat;
`endif
    end

    pipelined_rca_adder_slice #(.SW(SW)) u_slice (
      .i_a  (w_ain[SW-1:0]),
      .i_b  (w_bin[SW-1:0]),
      .i_ci (w_cin),
      .o_s  (w_ssl),
      .o_co (w_co),
      .o_cm (w_cm)
    );

    if (k == STAGES-1) begin : g_last
      logic w_ovf;
      assign w_ovf = w_co ^ w_cm;
`ifdef PIPELINED_RCA_ADDER_SAT_EN
      // On overflow the true sign is the inverse of the wrapped MSB
      assign w_sum_d = (w_sat_in & w_ovf) ?
                       {~w_snx[OW-1], {(OW-1){w_snx[OW-1]}}} : w_snx;
`else
      assign w_sum_d = w_snx;
`endif
      // Overflow flag registered alongside the final slice
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_ovf <= 1'b0;
        else if (w_en) r_ovf <= w_ovf;
      end
    end else begin : g_skew
      logic [IW-SW-1:0] r_au;
      logic [IW-SW-1:0] r_bu;
`ifdef PIPELINED_RCA_ADDER_SAT_EN
      logic             r_sat;
`endif
      assign w_sum_d = w_snx;
      // Carry the not-yet-added operand slices to the next stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_au <= '0;
          r_bu <= '0;
`ifdef PIPELINED_RCA_ADDER_SAT_EN
          r_sat <= 1'b0;
`endif
        end else if (w_en) begin
          r_au <= w_ain[IW-1:SW];
          r_bu <= w_bin[IW-1:SW];
`ifdef PIPELINED_RCA_ADDER_SAT_EN
          r_sat <= w_sat_in;
`endif
        end
      end
    end

    // Stage register: partial sum so far plus the slice carry-out
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum <= '0;
        r_cy  <= 1'b0;
      end else if (w_en) begin
        r_sum <= w_sum_d;
        r_cy  <= w_co;
      end
    end
  end

  assign bus.out_valid = w_vld_pipe[STAGES];
  assign bus.s         = stg[STAGES-1].r_sum;
  assign bus.c         = stg[STAGES-1].r_cy;
  assign bus.ovf       = r_ovf;
endmodule
